// File: rtl/iq_cic_decimator.sv
`default_nettype none
// ============================================================================
// Module   : iq_cic_decimator
// Brief    : Dual-rail (I/Q) CIC decimator for 1-bit interleaver streams.
// Revision : 1.0 - initial release
// ============================================================================
module iq_cic_decimator #(
   parameter  int STAGES   = 3,
   parameter  int DEC_LOG2 = 3,
   localparam int OUT_W    = 2 + STAGES * DEC_LOG2
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             IN_EN,
   input  logic             ODD_I,
   input  logic             EVEN_Q,
   output logic [OUT_W-1:0] I_OUT,
   output logic [OUT_W-1:0] Q_OUT,
   output logic             OUT_VALID
);

   localparam logic [DEC_LOG2-1:0] c_cnt_last = '1;

   // Rail index 0 carries I, rail index 1 carries Q.
   logic [OUT_W-1:0]    r_int   [2][STAGES];
   logic [OUT_W-1:0]    r_dly   [2][STAGES];
   logic [OUT_W-1:0]    r_out   [2];
   logic [DEC_LOG2-1:0] r_cnt;
   logic                r_valid;

   logic [OUT_W-1:0]    w_x     [2];
   logic [OUT_W-1:0]    w_chain [2][STAGES+1];
   logic                w_strobe;

   assign w_strobe = IN_EN && (r_cnt == c_cnt_last);

   // Bit 1 maps to +1, bit 0 to -1 (all ones in two's complement).
   always_comb begin
      w_x[0] = ODD_I  ? OUT_W'(1) : '1;
      w_x[1] = EVEN_Q ? OUT_W'(1) : '1;
   end

   // w_chain[r][k] is the input of comb stage k; w_chain[r][STAGES] is the result.
   always_comb begin
      for (int r = 0; r < 2; r++) begin
         w_chain[r][0] = r_int[r][STAGES-1];
         for (int k = 0; k < STAGES; k++) begin
            w_chain[r][k+1] = w_chain[r][k] - r_dly[r][k];
         end
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_cnt   <= '0;
         r_valid <= 1'b0;
         for (int r = 0; r < 2; r++) begin
            r_out[r] <= '0;
            for (int k = 0; k < STAGES; k++) begin
               r_int[r][k] <= '0;
               r_dly[r][k] <= '0;
            end
         end
      end else begin
         r_valid <= w_strobe;
         if (IN_EN) begin
            r_cnt <= r_cnt + DEC_LOG2'(1);
            // Pipelined integrator chain: every stage sees its neighbour's pre-edge value.
            for (int r = 0; r < 2; r++) begin
               r_int[r][0] <= r_int[r][0] + w_x[r];
               for (int k = 1; k < STAGES; k++) begin
                  r_int[r][k] <= r_int[r][k] + r_int[r][k-1];
               end
            end
         end
         if (w_strobe) begin
            for (int r = 0; r < 2; r++) begin
               r_out[r] <= w_chain[r][STAGES];
               for (int k = 0; k < STAGES; k++) begin
                  r_dly[r][k] <= w_chain[r][k];
               end
            end
         end
      end
   end

   assign I_OUT     = r_out[0];
   assign Q_OUT     = r_out[1];
   assign OUT_VALID = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_iq_cic_decimator.sv
`default_nettype none
// Testbench for iq_cic_decimator: default build plus STAGES=2/DEC_LOG2=2,
// both checked every cycle against a per-sample CIC reference model.
module tb_iq_cic_decimator;

   localparam int NCFG = 2;
   localparam int W_A  = 2 + 3 * 3;
   localparam int W_B  = 2 + 2 * 2;

   logic clk    = 1'b0;
   logic rst_n  = 1'b1;
   logic in_en  = 1'b0;
   logic odd_i  = 1'b0;
   logic even_q = 1'b0;

   logic [W_A-1:0] i_a, q_a;
   logic [W_B-1:0] i_b, q_b;
   logic           v_a, v_b;

   always #5 clk = ~clk;

   iq_cic_decimator dut_a (
      .CLK(clk), .RST(rst_n), .IN_EN(in_en), .ODD_I(odd_i), .EVEN_Q(even_q),
      .I_OUT(i_a), .Q_OUT(q_a), .OUT_VALID(v_a)
   );

   iq_cic_decimator #(.STAGES(2), .DEC_LOG2(2)) dut_b (
      .CLK(clk), .RST(rst_n), .IN_EN(in_en), .ODD_I(odd_i), .EVEN_Q(even_q),
      .I_OUT(i_b), .Q_OUT(q_b), .OUT_VALID(v_b)
   );

   int n_checks = 0;
   int n_err    = 0;

   int cst [NCFG] = '{3, 2};
   int cdl [NCFG] = '{3, 2};

   longint m_int [NCFG][2][5];
   longint m_dly [NCFG][2][5];
   longint m_out [NCFG][2];
   int     m_cnt [NCFG];
   bit     m_vld [NCFG];

   int  cyc = 0;
   int  mode = 0;          // 0 none, 1 DC +gain/-gain, 2 all zero
   int  period_mult = 0;   // 0 skip, else expected spacing = mult * DEC
   int  rec = 0;           // 1 record into dc_seq, 2 into g_seq
   int  pulses [NCFG];
   int  last_v [NCFG];
   bit  prev_v [NCFG];
   logic [2*W_A-1:0] dc_seq[$];
   logic [2*W_A-1:0] g_seq[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic longint wrapv(input int c, input longint v);
      longint m;
      m = (longint'(1) << (2 + cst[c] * cdl[c])) - 1;
      return v & m;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NCFG; c++) begin
         m_cnt[c] = 0; m_vld[c] = 0; pulses[c] = 0; last_v[c] = -1; prev_v[c] = 0;
         for (int r = 0; r < 2; r++) begin
            m_out[c][r] = 0;
            for (int k = 0; k < 5; k++) begin
               m_int[c][r][k] = 0;
               m_dly[c][r][k] = 0;
            end
         end
      end
   endtask

   // One accepted sample: comb on the last integrator's value before this sample,
   // then integrate the new sample.
   task automatic model_step(input bit en, input bit a, input bit b);
      longint old [5];
      longint v, x, nv;
      bit     strobe;
      for (int c = 0; c < NCFG; c++) begin
         m_vld[c] = 0;
         if (en) begin
            strobe = (m_cnt[c] == (1 << cdl[c]) - 1);
            for (int r = 0; r < 2; r++) begin
               for (int k = 0; k < 5; k++) old[k] = m_int[c][r][k];
               if (strobe) begin
                  v = old[cst[c]-1];
                  for (int k = 0; k < cst[c]; k++) begin
                     nv = wrapv(c, v - m_dly[c][r][k]);
                     m_dly[c][r][k] = v;
                     v = nv;
                  end
                  m_out[c][r] = v;
               end
               x = ((r == 0) ? a : b) ? 1 : -1;
               m_int[c][r][0] = wrapv(c, old[0] + x);
               for (int k = 1; k < cst[c]; k++)
                  m_int[c][r][k] = wrapv(c, old[k] + old[k-1]);
            end
            m_vld[c] = strobe;
            m_cnt[c] = (m_cnt[c] + 1) % (1 << cdl[c]);
         end
      end
   endtask

   task automatic check_outputs();
      logic [63:0] oi [NCFG];
      logic [63:0] oq [NCFG];
      logic        ov [NCFG];
      longint      g;
      oi[0] = 64'(i_a); oq[0] = 64'(q_a); ov[0] = v_a;
      oi[1] = 64'(i_b); oq[1] = 64'(q_b); ov[1] = v_b;
      for (int c = 0; c < NCFG; c++) begin
         check($sformatf("valid_cfg%0d", c), 64'(ov[c]), 64'(m_vld[c]));
         check($sformatf("i_out_cfg%0d", c), oi[c], m_out[c][0]);
         check($sformatf("q_out_cfg%0d", c), oq[c], m_out[c][1]);
         if (ov[c] === 1'b1) begin
            check($sformatf("valid_back_to_back_cfg%0d", c), 64'(prev_v[c]), 64'd0);
            pulses[c]++;
            if (period_mult != 0 && last_v[c] >= 0)
               check($sformatf("valid_period_cfg%0d", c), cyc - last_v[c], period_mult << cdl[c]);
            last_v[c] = cyc;
            g = longint'(1) << (cst[c] * cdl[c]);
            if (mode == 1 && pulses[c] > cst[c]) begin
               check($sformatf("dc_i_cfg%0d", c), oi[c], wrapv(c, g));
               check($sformatf("dc_q_cfg%0d", c), oq[c], wrapv(c, -g));
            end
            if (mode == 2 && pulses[c] > cst[c]) begin
               check($sformatf("alt_i_cfg%0d", c), oi[c], 64'd0);
               check($sformatf("alt_q_cfg%0d", c), oq[c], 64'd0);
            end
            if (c == 0 && rec == 1) dc_seq.push_back({i_a, q_a});
            if (c == 0 && rec == 2) g_seq.push_back({i_a, q_a});
         end
         prev_v[c] = ov[c];
      end
   endtask

   task automatic tick(input bit en, input bit a, input bit b);
      in_en = en; odd_i = a; even_q = b;
      @(posedge clk);
      #1;
      cyc++;
      model_step(en, a, b);
      check_outputs();
   endtask

   // Asserts reset off-edge and checks that everything clears before any clock.
   task automatic do_reset();
      in_en = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rst_i_a", 64'(i_a), 64'd0);
      check("rst_q_a", 64'(q_a), 64'd0);
      check("rst_v_a", 64'(v_a), 64'd0);
      check("rst_i_b", 64'(i_b), 64'd0);
      check("rst_q_b", 64'(q_b), 64'd0);
      check("rst_v_b", 64'(v_b), 64'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      bit found;
      int n;
      bit ph;
      model_reset();
      #2;
      do_reset();

      // DC: I all ones, Q all zeros, continuous enable.
      mode = 1; period_mult = 1; rec = 1;
      for (int k = 0; k < 100; k++) tick(1'b1, 1'b1, 1'b0);
      rec = 0;

      // Reset right during a valid pulse, then first-strobe latency.
      found = 0;
      for (int k = 0; k < 40 && !found; k++) begin
         tick(1'b1, 1'b1, 1'b0);
         if (v_a === 1'b1) found = 1;
      end
      check("wait_valid_before_reset", 64'(found), 64'd1);
      do_reset();
      n = 0;
      for (int k = 0; k < 8; k++) begin
         tick(1'b1, 1'b1, 1'b0);
         if (v_a === 1'b1 && n == 0) n = k + 1;
      end
      check("rst_first_valid_sample", n, 8);

      // Gated: same data, enable toggling 1/0.
      do_reset();
      mode = 1; period_mult = 2; rec = 2;
      for (int k = 0; k < 200; k++) tick(k[0] == 1'b0, 1'b1, 1'b0);
      rec = 0;
      check("gated_seq_len_ok", 64'(g_seq.size() >= 8 && dc_seq.size() >= 8), 64'd1);
      for (int k = 0; k < 8 && k < g_seq.size() && k < dc_seq.size(); k++)
         check($sformatf("gated_seq[%0d]", k), 64'(g_seq[k]), 64'(dc_seq[k]));

      // Alternating bits.
      do_reset();
      mode = 2; period_mult = 1; ph = 1'b1;
      for (int k = 0; k < 100; k++) begin
         tick(1'b1, ph, ~ph);
         ph = ~ph;
      end

      // Long run: integrators wrap many times, output must stay at the DC gain.
      do_reset();
      mode = 1; period_mult = 1;
      for (int k = 0; k < 20000; k++) tick(1'b1, 1'b1, 1'b0);

      // Random data with random enable.
      do_reset();
      mode = 0; period_mult = 0;
      for (int k = 0; k < 4000; k++)
         tick($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom));

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
